regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the RISC-V core, successor to the 2-read/1-write file. Configurable read and write port counts, same-cycle write-to-read forwarding, deterministic multi-write priority, and a per-register busy scoreboard for the issue stage. Sits between decode/issue (reads, reservations) and writeback (writes).

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_fwd.sv | 40 ++++
 rtl/regfile_mp.sv | 113 +++++++++++
 tb/tb_regfile_mp.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and slice helpers for the multi-port
// integer register file.
package regfile_pkg;

   localparam int DEF_WORD_SIZE = 32;
   localparam int DEF_NUM_REGS  = 32;
   localparam int ZERO_IDX      = 0;

   function automatic int sel_lo(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/regfile_fwd.sv
// regfile_fwd: one read port with write-first forwarding.
// The highest-index matching write port supplies the data.
module regfile_fwd
   import regfile_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int REG_SEL   = 5,
   parameter int NUM_WR    = 1,
   parameter int ZERO_REG  = 1
) (
   input  logic [REG_SEL-1:0]          rd_sel_i,
   input  logic [WORD_SIZE-1:0]        stored_i,
   input  logic                        busy_i,
   input  logic [NUM_WR-1:0]           we_i,
   input  logic [NUM_WR*REG_SEL-1:0]   wsel_i,
   input  logic [NUM_WR*WORD_SIZE-1:0] wdata_i,
   output logic [WORD_SIZE-1:0]        data_o,
   output logic                        busy_o
);

   logic                 hit;
   logic                 zero;
   logic [WORD_SIZE-1:0] fwd;

   always_comb begin
      hit  = 1'b0;
      fwd  = stored_i;
      zero = (ZERO_REG != 0) && (rd_sel_i == REG_SEL'(ZERO_IDX));
      for (int j = 0; j < NUM_WR; j++) begin
         if (we_i[j] &&
             wsel_i[sel_lo(j, REG_SEL) +: REG_SEL] == rd_sel_i) begin
            hit = 1'b1;
            fwd = wdata_i[sel_lo(j, WORD_SIZE) +: WORD_SIZE];
         end
      end
      data_o = zero ? '0 : fwd;
      busy_o = busy_i & ~hit;
   end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with forwarding,
// write priority and a per-register busy scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int NUM_REGS  = DEF_NUM_REGS,
   parameter int REG_SEL   = $clog2(NUM_REGS),
   parameter int NUM_RD    = 2,
   parameter int NUM_WR    = 1,
   parameter int ZERO_REG  = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_RD*REG_SEL-1:0]   rdSel,
   output logic [NUM_RD*WORD_SIZE-1:0] rdData,
   output logic [NUM_RD-1:0]           rdBusy,
   input  logic [NUM_WR-1:0]           wCtrl,
   input  logic [NUM_WR*REG_SEL-1:0]   wSel,
   input  logic [NUM_WR*WORD_SIZE-1:0] wData,
   input  logic                        resvCtrl,
   input  logic [REG_SEL-1:0]          resvSel,
   output logic                        wConflict
);

   logic [WORD_SIZE-1:0] mem_q [NUM_REGS];
   logic [WORD_SIZE-1:0] mem_d [NUM_REGS];
   logic [NUM_REGS-1:0]  busy_q, busy_d;
   logic                 conf_q, conf_d;

   logic [REG_SEL-1:0]   wsel_a [NUM_WR];
   logic [NUM_WR-1:0]    wlive;
   logic [NUM_WR-1:0]    wacc;
   logic                 resv_acc;

   function automatic logic is_zero(input logic [REG_SEL-1:0] s);
      return (ZERO_REG != 0) && (s == REG_SEL'(ZERO_IDX));
   endfunction

   always_comb begin
      for (int j = 0; j < NUM_WR; j++) begin
         wsel_a[j] = wSel[sel_lo(j, REG_SEL) +: REG_SEL];
         wlive[j]  = wCtrl[j] & ~rst;
         wacc[j]   = wlive[j] & ~is_zero(wsel_a[j]);
      end
      resv_acc = resvCtrl & ~rst & ~is_zero(resvSel);
   end

   // Later ports overwrite earlier ones, so the highest index wins.
   always_comb begin
      mem_d  = mem_q;
      busy_d = busy_q;
      for (int j = 0; j < NUM_WR; j++) begin
         if (wacc[j]) begin
            mem_d[wsel_a[j]]  = wData[sel_lo(j, WORD_SIZE) +: WORD_SIZE];
            busy_d[wsel_a[j]] = 1'b0;
         end
      end
      if (resv_acc) begin
         busy_d[resvSel] = 1'b1;
      end
   end

   always_comb begin
      conf_d = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
         for (int k = j + 1; k < NUM_WR; k++) begin
            if (wacc[j] && wacc[k] && wsel_a[j] == wsel_a[k] &&
                wsel_a[j] != REG_SEL'(ZERO_IDX)) begin
               conf_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            mem_q[r] <= '0;
         end
         busy_q <= '0;
         conf_q <= 1'b0;
      end else begin
         mem_q  <= mem_d;
         busy_q <= busy_d;
         conf_q <= conf_d;
      end
   end

   assign wConflict = conf_q;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [REG_SEL-1:0] sel;
      assign sel = rdSel[i*REG_SEL +: REG_SEL];

      regfile_fwd #(
         .WORD_SIZE (WORD_SIZE),
         .REG_SEL   (REG_SEL),
         .NUM_WR    (NUM_WR),
         .ZERO_REG  (ZERO_REG)
      ) u_fwd (
         .rd_sel_i  (sel),
         .stored_i  (mem_q[sel]),
         .busy_i    (busy_q[sel]),
         .we_i      (wlive),
         .wsel_i    (wSel),
         .wdata_i   (wData),
         .data_o    (rdData[i*WORD_SIZE +: WORD_SIZE]),
         .busy_o    (rdBusy[i])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed plus random stimulus against an array model
// of the register file, scoreboard and conflict flag.
module tb_regfile_mp;

   localparam int W  = 32;
   localparam int N  = 32;
   localparam int S  = 5;
   localparam int NR = 2;
   localparam int NW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [NR*S-1:0] rdSel;
   logic [NR*W-1:0] rdData;
   logic [NR-1:0]   rdBusy;
   logic [NW-1:0]   wCtrl;
   logic [NW*S-1:0] wSel;
   logic [NW*W-1:0] wData;
   logic            resvCtrl;
   logic [S-1:0]    resvSel;
   logic            wConflict;

   regfile_mp #(
      .WORD_SIZE (W),
      .NUM_REGS  (N),
      .NUM_RD    (NR),
      .NUM_WR    (NW),
      .ZERO_REG  (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rdSel     (rdSel),
      .rdData    (rdData),
      .rdBusy    (rdBusy),
      .wCtrl     (wCtrl),
      .wSel      (wSel),
      .wData     (wData),
      .resvCtrl  (resvCtrl),
      .resvSel   (resvSel),
      .wConflict (wConflict)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] m_reg [N];
   bit           m_busy [N];
   bit           m_conf;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic void m_reset();
      for (int r = 0; r < N; r++) begin
         m_reg[r]  = '0;
         m_busy[r] = 1'b0;
      end
      m_conf = 1'b0;
   endfunction

   function automatic logic [W-1:0] m_data(input int p);
      int           sel;
      logic [W-1:0] d;
      sel = int'(rdSel[p*S +: S]);
      if (rst || sel == 0) return '0;
      d = m_reg[sel];
      for (int j = 0; j < NW; j++)
         if (wCtrl[j] && int'(wSel[j*S +: S]) == sel) d = wData[j*W +: W];
      return d;
   endfunction

   function automatic bit m_bsy(input int p);
      int sel;
      sel = int'(rdSel[p*S +: S]);
      if (rst) return 1'b0;
      for (int j = 0; j < NW; j++)
         if (wCtrl[j] && int'(wSel[j*S +: S]) == sel) return 1'b0;
      return m_busy[sel];
   endfunction

   function automatic void m_commit();
      int s0, s1;
      s0 = int'(wSel[0 +: S]);
      s1 = int'(wSel[S +: S]);
      m_conf = wCtrl[0] && wCtrl[1] && s0 == s1 && s0 != 0;
      for (int j = 0; j < NW; j++) begin
         int s;
         s = int'(wSel[j*S +: S]);
         if (wCtrl[j] && s != 0) begin
            m_reg[s]  = wData[j*W +: W];
            m_busy[s] = 1'b0;
         end
      end
      if (resvCtrl && resvSel != 0) m_busy[int'(resvSel)] = 1'b1;
   endfunction

   task automatic check_reads(input string tag);
      for (int p = 0; p < NR; p++) begin
         chk($sformatf("%s.rd%0d", tag, p), rdData[p*W +: W], m_data(p));
         chk($sformatf("%s.bz%0d", tag, p), rdBusy[p], m_bsy(p));
      end
   endtask

   task automatic drv(input int r0, input int r1, input logic [1:0] wc,
                      input int s0, input int s1,
                      input logic [W-1:0] d0, input logic [W-1:0] d1,
                      input logic rc, input int rs);
      rdSel    = {S'(r1), S'(r0)};
      wCtrl    = wc;
      wSel     = {S'(s1), S'(s0)};
      wData    = {d1, d0};
      resvCtrl = rc;
      resvSel  = S'(rs);
   endtask

   task automatic step(input string tag);
      #1;
      check_reads(tag);
      @(posedge clk);
      if (rst) m_reset();
      else m_commit();
      #1;
      chk({tag, ".conf"}, {63'd0, wConflict}, {63'd0, m_conf});
   endtask

   task automatic idle(input int r0, input int r1);
      drv(r0, r1, 2'b00, 0, 0, '0, '0, 1'b0, 0);
   endtask

   initial begin
      m_reset();
      rst = 1'b1;
      idle(0, 0);
      @(posedge clk);
      #1;
      // reset sweep plus a write attempt that must be ignored
      for (int i = 0; i < N; i++) begin
         drv(i, N - 1 - i, 2'b01, 12, 0, 32'hDEADBEEF, '0, 1'b1, i);
         #1;
         check_reads($sformatf("rst%0d", i));
      end
      @(posedge clk);
      m_reset();
      #1;
      rst = 1'b0;
      idle(12, 0);
      #1;
      chk("rst_x12", rdData[0 +: W], 32'h0);
      step("post_rst");

      drv(12, 0, 2'b01, 12, 0, 32'hDEADBEEF, '0, 1'b0, 0);
      #1;
      chk("fwd_x12", rdData[0 +: W], 32'hDEADBEEF);
      step("w12");
      drv(12, 0, 2'b01, 0, 0, 32'h87654321, '0, 1'b0, 0);
      #1;
      chk("x12_hold", rdData[0 +: W], 32'hDEADBEEF);
      chk("x0_zero", rdData[W +: W], 32'h0);
      step("w0");

      drv(5, 0, 2'b11, 5, 5, 32'h11111111, 32'h22222222, 1'b0, 0);
      #1;
      chk("fwd_prio", rdData[0 +: W], 32'h22222222);
      step("conf");
      chk("conf_hi", {63'd0, wConflict}, 64'd1);
      idle(5, 0);
      #1;
      chk("x5_val", rdData[0 +: W], 32'h22222222);
      step("conf2");
      chk("conf_lo", {63'd0, wConflict}, 64'd0);

      drv(0, 0, 2'b00, 0, 0, '0, '0, 1'b1, 7);
      step("resv7");
      idle(0, 7);
      #1;
      chk("busy7", {63'd0, rdBusy[1]}, 64'd1);
      step("rd7");
      drv(0, 7, 2'b01, 7, 0, 32'hABCDABCD, '0, 1'b0, 0);
      #1;
      chk("fwd7_bz", {63'd0, rdBusy[1]}, 64'd0);
      chk("fwd7_d", rdData[W +: W], 32'hABCDABCD);
      step("w7");
      idle(7, 0);
      #1;
      chk("clr7", {63'd0, rdBusy[0]}, 64'd0);
      step("rd7b");

      drv(0, 0, 2'b10, 0, 9, '0, 32'h0909CAFE, 1'b1, 9);
      step("rw9");
      idle(9, 9);
      #1;
      chk("busy9", {63'd0, rdBusy[0]}, 64'd1);
      chk("data9", rdData[0 +: W], 32'h0909CAFE);
      step("rd9");

      drv(0, 0, 2'b01, 16, 0, 32'hFEFEFE00, '0, 1'b0, 0);
      step("w16");
      drv(16, 0, 2'b01, 19, 0, 32'h00088800, '0, 1'b0, 0);
      step("w19");
      idle(16, 19);
      #2;
      rst = 1'b1;
      #1;
      chk("arst16", rdData[0 +: W], 32'h0);
      chk("arst19", rdData[W +: W], 32'h0);
      chk("arst_bz", {62'd0, rdBusy}, 64'd0);
      m_reset();
      rst = 1'b0;
      step("after_arst");

      // random traffic over a small register window to provoke hits
      for (int n = 0; n < 600; n++) begin
         int lim;
         lim = ($urandom_range(0, 3) == 0) ? N - 1 : 7;
         rst = ($urandom_range(0, 60) == 0);
         drv($urandom_range(0, lim), $urandom_range(0, lim),
             2'($urandom_range(0, 3)),
             $urandom_range(0, lim), $urandom_range(0, lim),
             $urandom, $urandom,
             1'($urandom_range(0, 1)), $urandom_range(0, lim));
         step($sformatf("rnd%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
